alsu_pipe: RTL and testbench

- Parametrised, handshaked next-generation ALSU.
- Operand width is generic (WIDTH), and the output is widened to 2*WIDTH so add and multiply never truncate.
- Flow: one registered input stage, then one execute stage. Multiply is a multi-cycle sequential shift-add unit that back-pressures upstream through in_ready.
- Sits between the stimulus/control front end and the LED/display logic.

---
 rtl/alsu_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_alsu_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alsu_pipe.sv
// alsu_pipe: handshaked ALSU. One registered input stage, then an execute
// stage. MUL runs on a sequential shift-add unit and holds in_ready low.
// Ports: clk, rst_n (async, active low); in_valid/in_ready handshake;
// A, B, opcode, cin, serial_in, direction, red_op_A/B, bypass_A/B inputs;
// out (2*WIDTH), out_valid (1-cycle pulse), leds (invalid-op indicator).
module alsu_pipe #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int LED_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic [LED_W-1:0]     leds
);
    localparam int OW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam bit PRI_B = (INPUT_PRIORITY == "B");
    localparam bit FA_ON = (FULL_ADDER == "ON");

    typedef enum logic {IDLE, MULS} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d, ser_q, ser_d, dir_q, dir_d;
    logic             ra_q, ra_d, rb_q, rb_d, ba_q, ba_d, bb_q, bb_d;
    logic             s1_valid_q, s1_valid_d;
    logic [OW-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    out_q, out_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic             ov_q, ov_d;

    logic             accept, exec, bypass, invalid, is_mul;
    logic [OW-1:0]    a_ext, b_ext, red_val, acc_step;
    logic [WIDTH-1:0] a_mag, b_mag, red_src;
    logic             red_any, red_bit;

    assign bypass  = ba_q | bb_q;
    assign invalid = (op_q[2] & op_q[1])
                   | ((ra_q | rb_q) & (op_q[2:1] != 2'b00));
    assign is_mul  = !bypass && !invalid && (op_q == 3'd3);

    assign in_ready = (state_q == IDLE) && !(s1_valid_q && is_mul);
    assign accept   = in_valid && in_ready;
    assign exec     = s1_valid_q && (state_q == IDLE);

    assign a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit value
    assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
    assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;

    // Reduction picks B only when B alone is flagged, or both and B has priority
    assign red_any = ra_q | rb_q;
    assign red_src = ((rb_q && !ra_q) || (ra_q && rb_q && PRI_B)) ? b_q : a_q;
    assign red_bit = op_q[0] ? ^red_src : |red_src;
    assign red_val = {{(OW-1){1'b0}}, red_bit};

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cin_d      = cin_q;
        ser_d      = ser_q;
        dir_d      = dir_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        ba_d       = ba_q;
        bb_d       = bb_q;
        s1_valid_d = s1_valid_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        leds_d     = leds_q;
        ov_d       = 1'b0;

        if (exec) s1_valid_d = 1'b0;
        if (accept) begin
            a_d        = A;
            b_d        = B;
            op_d       = opcode;
            cin_d      = cin;
            ser_d      = serial_in;
            dir_d      = direction;
            ra_d       = red_op_A;
            rb_d       = red_op_B;
            ba_d       = bypass_A;
            bb_d       = bypass_B;
            s1_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (exec && is_mul) begin
                    // Load edge already consumes multiplier bit 0, so the
                    // product lands WIDTH edges after accept.
                    acc_d    = b_mag[0] ? {{WIDTH{1'b0}}, a_mag} : '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag} << 1;
                    mplier_d = b_mag >> 1;
                    neg_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    cnt_d    = CW'(WIDTH - 2);
                    state_d  = MULS;
                end else if (exec) begin
                    ov_d   = 1'b1;
                    leds_d = (invalid && !bypass) ? ~leds_q : '0;
                    if (ba_q && bb_q)  out_d = PRI_B ? b_ext : a_ext;
                    else if (ba_q)     out_d = a_ext;
                    else if (bb_q)     out_d = b_ext;
                    else if (invalid)  out_d = '0;
                    else begin
                        unique case (op_q)
                            3'd0: out_d = red_any ? red_val : (a_ext | b_ext);
                            3'd1: out_d = red_any ? red_val : (a_ext ^ b_ext);
                            3'd2: out_d = a_ext + b_ext
                                        + {{(OW-1){1'b0}}, FA_ON & cin_q};
                            3'd4: out_d = dir_q ? {out_q[OW-2:0], ser_q}
                                                : {ser_q, out_q[OW-1:1]};
                            3'd5: out_d = dir_q ? {out_q[OW-2:0], out_q[OW-1]}
                                                : {out_q[0], out_q[OW-1:1]};
                            default: out_d = '0;
                        endcase
                    end
                end
            end
            MULS: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    out_d   = neg_q ? -acc_step : acc_step;
                    leds_d  = '0;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cin_q      <= 1'b0;
            ser_q      <= 1'b0;
            dir_q      <= 1'b0;
            ra_q       <= 1'b0;
            rb_q       <= 1'b0;
            ba_q       <= 1'b0;
            bb_q       <= 1'b0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            out_q      <= '0;
            leds_q     <= '0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cin_q      <= cin_d;
            ser_q      <= ser_d;
            dir_q      <= dir_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            ba_q       <= ba_d;
            bb_q       <= bb_d;
            s1_valid_q <= s1_valid_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            leds_q     <= leds_d;
            ov_q       <= ov_d;
        end
    end

    assign out       = out_q;
    assign leds      = leds_q;
    assign out_valid = ov_q;
endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: scoreboard bench for alsu_pipe (WIDTH=4, OW=8).
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_alsu_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  a = '0, b = '0;
    logic [2:0]  opcode = '0;
    logic        cin = 0, serial_in = 0, direction = 0;
    logic        red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;
    logic [7:0]  out;
    logic        out_valid;
    logic [15:0] leds;

    alsu_pipe #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
                .LED_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out),
        .out_valid(out_valid), .leds(leds)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] F_CIN = 7'b1000000;
    localparam logic [6:0] F_SER = 7'b0100000;
    localparam logic [6:0] F_DIR = 7'b0010000;
    localparam logic [6:0] F_RA  = 7'b0001000;
    localparam logic [6:0] F_RB  = 7'b0000100;
    localparam logic [6:0] F_BA  = 7'b0000010;
    localparam logic [6:0] F_BB  = 7'b0000001;

    typedef struct {
        logic [7:0]  out;
        logic [15:0] leds;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   seen = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            seen++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid out=%h leds=%h cyc=%0d",
                         out, leds, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out !== e.out || leds !== e.leds || cyc != e.due) begin
                    errors++;
                    $display("FAIL result got out=%h leds=%h cyc=%0d exp out=%h leds=%h cyc=%0d",
                             out, leds, cyc, e.out, e.leds, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] av,
                        input logic [3:0] bv, input logic [6:0] fl,
                        input logic [7:0] eo, input logic [15:0] el,
                        input int lat, output int waits);
        opcode    = op;
        a         = av;
        b         = bv;
        cin       = fl[6];
        serial_in = fl[5];
        direction = fl[4];
        red_op_A  = fl[3];
        red_op_B  = fl[2];
        bypass_A  = fl[1];
        bypass_B  = fl[0];
        in_valid  = 1'b1;
        waits     = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d waits=%0d", op, waits);
        end else begin
            @(posedge clk);
            #1;
            q.push_back('{eo, el, cyc + lat});
        end
        in_valid = 1'b0;
    endtask

    task automatic tx(input logic [2:0] op, input logic [3:0] av,
                      input logic [3:0] bv, input logic [6:0] fl,
                      input logic [7:0] eo, input logic [15:0] el);
        int w;
        send(op, av, bv, fl, eo, el, 1, w);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    initial begin
        int w;
        int s;
        logic [7:0] r;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out, 0);
        chk("reset_leds", leds, 0);
        chk("reset_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1);

        // ADD 1+2 completes, then a second ADD is killed by reset
        tx(3'd2, 4'd1, 4'd2, 7'b0, 8'h03, 16'h0);
        drain();
        tx(3'd2, 4'd1, 4'd1, 7'b0, 8'h02, 16'h0);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midstream_rst_out", out, 0);
        chk("midstream_rst_leds", leds, 0);
        chk("midstream_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // both bypass flags: A wins, sign-extended
        tx(3'd2, 4'hD, 4'h5, F_BA | F_BB, 8'hFD, 16'h0);
        tx(3'd2, 4'd7, 4'd7, F_CIN, 8'h0F, 16'h0);
        tx(3'd2, 4'h8, 4'h8, 7'b0, 8'hF0, 16'h0);
        drain();

        // MUL -8*-8 then a held ADD accepted only when in_ready returns
        send(3'd3, 4'h8, 4'h8, 7'b0, 8'h40, 16'h0, 4, w);
        send(3'd2, 4'd1, 4'd2, 7'b0, 8'h03, 16'h0, 1, w);
        chk("mul_stall_cycles", w, 4);
        send(3'd3, 4'd3, 4'hB, 7'b0, 8'hF1, 16'h0, 4, w);
        drain();

        // invalid ops toggle leds
        tx(3'd7, 4'd1, 4'd1, 7'b0, 8'h00, 16'hFFFF);
        tx(3'd7, 4'd1, 4'd1, 7'b0, 8'h00, 16'h0000);
        tx(3'd7, 4'd1, 4'd1, 7'b0, 8'h00, 16'hFFFF);
        tx(3'd0, 4'b0010, 4'd0, F_RA, 8'h01, 16'h0);
        tx(3'd2, 4'd3, 4'd3, F_RB, 8'h00, 16'hFFFF);
        tx(3'd1, 4'b0101, 4'b1100, 7'b0, 8'hF9, 16'h0);
        drain();

        // preload 1, rotate left a full turn, then shift right with 1 in
        tx(3'd0, 4'd1, 4'd0, F_BA, 8'h01, 16'h0);
        r = 8'h01;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], r[7]};
            tx(3'd5, 4'd0, 4'd0, F_DIR, r, 16'h0);
        end
        tx(3'd4, 4'd0, 4'd0, F_SER, 8'h80, 16'h0);
        drain();
        chk("rotate_full_turn", r, 8'h01);

        // reset two cycles into a multiply
        send(3'd3, 4'd3, 4'd3, 7'b0, 8'h09, 16'h0, 4, w);
        repeat (2) @(posedge clk);
        #1;
        s = seen;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mulrst_out", out, 0);
        chk("mulrst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mulrst_no_pulse", seen - s, 0);
        chk("mulrst_idle_ready", in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
